// File: rtl/ecc_op_sequencer_if.sv
// Handshake bundle between the ECC operation sequencer, its register side and the
// encoder/decoder engines.
interface ecc_op_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  start;
    logic [1:0]            operation;
    logic [1:0]            code_width;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] noise;
    logic                  enc_req;
    logic [DATA_WIDTH-1:0] enc_data;
    logic                  enc_ack;
    logic [DATA_WIDTH-1:0] enc_result;
    logic                  dec_req;
    logic [DATA_WIDTH-1:0] dec_data;
    logic                  dec_ack;
    logic [DATA_WIDTH-1:0] dec_result;
    logic [1:0]            dec_num_err;
    logic                  busy;
    logic                  operation_done;
    logic [DATA_WIDTH-1:0] data_out;
    logic [1:0]            num_of_errors;
    logic                  op_error;

    modport slave (
        input  start, operation, code_width, data_in, noise,
        input  enc_ack, enc_result, dec_ack, dec_result, dec_num_err,
        output enc_req, enc_data, dec_req, dec_data,
        output busy, operation_done, data_out, num_of_errors, op_error
    );

    modport master (
        output start, operation, code_width, data_in, noise,
        output enc_ack, enc_result, dec_ack, dec_result, dec_num_err,
        input  enc_req, enc_data, dec_req, dec_data,
        input  busy, operation_done, data_out, num_of_errors, op_error
    );
endinterface

// File: rtl/ecc_op_sequencer.sv
// Sequences one encode / decode / full-channel operation across the shared ECC engines,
// with code-width masking, noise injection and an engine-ack timeout.
module ecc_op_sequencer #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic                clk,
    input logic                rst,
    ecc_op_sequencer_if.slave  bus
);
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 2);

    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef enum logic [2:0] {StIdle, StEnc, StNoise, StDec, StDone} state_e;

    function automatic word_t width_mask(input logic [1:0] cw);
        int    len;
        word_t m;
        case (cw)
            2'd1:    len = 8;
            2'd2:    len = 16;
            default: len = 32;
        endcase
        for (int i = 0; i < DATA_WIDTH; i++) m[i] = (i < len);
        return m;
    endfunction

    state_e          state_q, state_d;
    logic [1:0]      op_q, op_d;
    word_t           mask_q, mask_d, data_q, data_d, noise_q, noise_d;
    word_t           cword_q, cword_d, res_q, res_d, data_out_q, data_out_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      res_err_q, res_err_d, nerr_q, nerr_d;
    logic            res_flag_q, res_flag_d, op_error_q, op_error_d, done_q;
    logic            timed_out;

    assign timed_out = (cnt_q == CntW'(TIMEOUT_CYCLES));

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        mask_d     = mask_q;
        data_d     = data_q;
        noise_d    = noise_q;
        cword_d    = cword_q;
        cnt_d      = cnt_q;
        res_d      = res_q;
        res_err_d  = res_err_q;
        res_flag_d = res_flag_q;
        data_out_d = data_out_q;
        nerr_d     = nerr_q;
        op_error_d = op_error_q;
        unique case (state_q)
            StIdle: begin
                // The done pulse is issued from Idle, so a start coincident with it is dropped.
                if (bus.start && !done_q) begin
                    op_d       = bus.operation;
                    mask_d     = width_mask(bus.code_width);
                    data_d     = bus.data_in;
                    noise_d    = bus.noise;
                    cword_d    = bus.data_in & width_mask(bus.code_width);
                    cnt_d      = '0;
                    op_error_d = 1'b0;
                    res_d      = '0;
                    res_err_d  = '0;
                    res_flag_d = 1'b0;
                    unique case (bus.operation)
                        2'd0, 2'd2: state_d = StEnc;
                        2'd1:       state_d = StDec;
                        default: begin
                            res_flag_d = 1'b1;
                            state_d    = StDone;
                        end
                    endcase
                end
            end
            StEnc: begin
                if (bus.enc_ack) begin
                    if (op_q == 2'd2) begin
                        cword_d = bus.enc_result & mask_q;
                        state_d = StNoise;
                    end else begin
                        res_d   = bus.enc_result & mask_q;
                        state_d = StDone;
                    end
                end else if (timed_out) begin
                    res_flag_d = 1'b1;
                    state_d    = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StNoise: begin
                cword_d = cword_q ^ (noise_q & mask_q);
                cnt_d   = '0;
                state_d = StDec;
            end
            StDec: begin
                if (bus.dec_ack) begin
                    res_d     = bus.dec_result & mask_q;
                    res_err_d = bus.dec_num_err;
                    state_d   = StDone;
                end else if (timed_out) begin
                    res_flag_d = 1'b1;
                    state_d    = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                // Results become visible together with the registered done pulse.
                data_out_d = res_q;
                nerr_d     = res_err_q;
                op_error_d = res_flag_q;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            op_q       <= '0;
            mask_q     <= '0;
            data_q     <= '0;
            noise_q    <= '0;
            cword_q    <= '0;
            cnt_q      <= '0;
            res_q      <= '0;
            res_err_q  <= '0;
            res_flag_q <= 1'b0;
            data_out_q <= '0;
            nerr_q     <= '0;
            op_error_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            mask_q     <= mask_d;
            data_q     <= data_d;
            noise_q    <= noise_d;
            cword_q    <= cword_d;
            cnt_q      <= cnt_d;
            res_q      <= res_d;
            res_err_q  <= res_err_d;
            res_flag_q <= res_flag_d;
            data_out_q <= data_out_d;
            nerr_q     <= nerr_d;
            op_error_q <= op_error_d;
            done_q     <= (state_q == StDone);
        end
    end

    assign bus.enc_req        = (state_q == StEnc);
    assign bus.enc_data       = data_q & mask_q;
    assign bus.dec_req        = (state_q == StDec);
    assign bus.dec_data       = cword_q;
    assign bus.busy           = (state_q != StIdle);
    assign bus.operation_done = done_q;
    assign bus.data_out       = data_out_q;
    assign bus.num_of_errors  = nerr_q;
    assign bus.op_error       = op_error_q;
endmodule

// File: tb/tb_ecc_op_sequencer.sv
// Directed plus randomized operations against a cycle-budget reference model of the sequencer.
module tb_ecc_op_sequencer;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 255;
    localparam int NEVER = 1000;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ecc_op_sequencer_if #(.DATA_WIDTH(DW)) bus ();

    ecc_op_sequencer #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        if (o !== e) begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    function automatic logic [31:0] mask_of(input logic [1:0] cw);
        case (cw)
            2'd1:    return 32'h0000_00FF;
            2'd2:    return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [1:0] cw, input logic [31:0] din,
                          input logic [31:0] nz, input logic [31:0] er, input logic [31:0] dr,
                          input logic [1:0] derr, input int ed, input int dd, input bit dbl);
        logic [31:0] m, exp_out, exp_encd, exp_decd, got_out, enc_seen, dec_seen;
        logic [1:0]  exp_err, got_err;
        logic        exp_flag, got_flag;
        int          exp_done, done_cyc, pulses, ew, dwt;
        m        = mask_of(cw);
        exp_encd = din & m;
        exp_decd = (op == 2'd1) ? (din & m) : ((er & m) ^ (nz & m));
        exp_out  = '0;
        exp_err  = '0;
        exp_flag = 1'b1;
        // Latency: req from cycle 1, each engine stage ends at its ack or at TO waited cycles,
        // then two cycles to the pulse; full mode adds the noise cycle and the decode entry.
        case (op)
            2'd0: exp_done = 3 + ((ed > TO) ? TO : ed);
            2'd1: exp_done = 3 + ((dd > TO) ? TO : dd);
            2'd2: exp_done = (ed > TO) ? 3 + TO : 5 + ed + ((dd > TO) ? TO : dd);
            default: exp_done = 2;
        endcase
        if (op == 2'd0 && ed <= TO) begin
            exp_out = er & m; exp_flag = 1'b0;
        end else if ((op == 2'd1 && dd <= TO) || (op == 2'd2 && ed <= TO && dd <= TO)) begin
            exp_out = dr & m; exp_err = derr; exp_flag = 1'b0;
        end
        done_cyc = -1; pulses = 0; ew = 0; dwt = 0;
        enc_seen = 'x; dec_seen = 'x; got_out = 'x; got_err = 'x; got_flag = 1'bx;

        @(negedge clk);
        bus.start = 1'b1; bus.operation = op; bus.code_width = cw;
        bus.data_in = din; bus.noise = nz; bus.enc_ack = 1'b0; bus.dec_ack = 1'b0;
        for (int cyc = 1; cyc <= exp_done + 2; cyc++) begin
            @(negedge clk);
            bus.start      = (dbl && cyc == 1);
            bus.operation  = 2'($urandom);
            bus.code_width = 2'($urandom);
            bus.data_in    = $urandom;
            bus.noise      = $urandom;
            if (cyc == 1) begin
                chk("busy_after_start", bus.busy, 1'b1);
                chk("op_error_cleared", bus.op_error, 1'b0);
            end
            if (bus.operation_done) begin
                pulses++;
                if (pulses == 1) begin
                    done_cyc = cyc; got_out = bus.data_out;
                    got_err = bus.num_of_errors; got_flag = bus.op_error;
                    bus.start = 1'b1;
                end
            end
            if (pulses > 0 && cyc == done_cyc + 1) chk("start_at_done_ignored", bus.busy, 1'b0);
            if (bus.enc_req) begin
                if (ew == 0) enc_seen = bus.enc_data;
                bus.enc_ack    = (ew == ed);
                bus.enc_result = (ew == ed) ? er : $urandom;
                ew++;
            end else begin
                bus.enc_ack = ($urandom_range(3) == 0); bus.enc_result = $urandom;
            end
            if (bus.dec_req) begin
                if (dwt == 0) dec_seen = bus.dec_data;
                bus.dec_ack     = (dwt == dd);
                bus.dec_result  = (dwt == dd) ? dr : $urandom;
                bus.dec_num_err = (dwt == dd) ? derr : 2'($urandom);
                dwt++;
            end else begin
                bus.dec_ack = ($urandom_range(3) == 0);
                bus.dec_result = $urandom; bus.dec_num_err = 2'($urandom);
            end
        end
        bus.start = 1'b0; bus.enc_ack = 1'b0; bus.dec_ack = 1'b0;
        chk("done_pulse_count", pulses, 1);
        chk("done_latency", done_cyc, exp_done);
        chk("data_out", got_out, exp_out);
        chk("num_of_errors", got_err, exp_err);
        chk("op_error", got_flag, exp_flag);
        chk("data_out_held", bus.data_out, exp_out);
        if (op == 2'd0 || op == 2'd2) chk("enc_data", enc_seen, exp_encd);
        if (op == 2'd1 || (op == 2'd2 && ed <= TO)) chk("dec_data", dec_seen, exp_decd);
    endtask

    initial begin
        int pulses;
        rst = 1'b1;
        bus.start = 1'b1; bus.operation = 2'd3; bus.code_width = 2'd0;
        bus.data_in = $urandom; bus.noise = $urandom;
        bus.enc_ack = 1'b1; bus.enc_result = $urandom;
        bus.dec_ack = 1'b1; bus.dec_result = $urandom; bus.dec_num_err = 2'd2;
        repeat (3) @(negedge clk);
        chk("rst_enc_req", bus.enc_req, 1'b0);
        chk("rst_dec_req", bus.dec_req, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.operation_done, 1'b0);
        chk("rst_data_out", bus.data_out, 32'h0);
        chk("rst_nerr", bus.num_of_errors, 2'd0);
        chk("rst_op_error", bus.op_error, 1'b0);
        bus.start = 1'b0; bus.enc_ack = 1'b0; bus.dec_ack = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // T1 encode, T2/T3 full channel
        run_op(2'd0, 2'd1, 32'h0000_000B, 32'h0, 32'hFFFF_FF5B, 32'h0, 2'd0, 0, 0, 1'b0);
        run_op(2'd2, 2'd3, $urandom, 32'h0000_0100, 32'h1234_5678, 32'h0034_5678, 2'd1,
               0, 0, 1'b0);

        // T6 reset while waiting in decode
        @(negedge clk);
        bus.start = 1'b1; bus.operation = 2'd1; bus.code_width = 2'd3; bus.data_in = $urandom;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_dec_req_pending", bus.dec_req, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_dec_req", bus.dec_req, 1'b0);
        chk("t6_busy", bus.busy, 1'b0);
        chk("t6_data_out", bus.data_out, 32'h0);
        chk("t6_nerr", bus.num_of_errors, 2'd0);
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.operation_done) pulses++;
        end
        chk("t6_no_done", pulses, 0);
        run_op(2'd3, 2'd1, $urandom, $urandom, 32'h0, 32'h0, 2'd0, 0, 0, 1'b0);

        run_op(2'd2, 2'd2, $urandom, 32'h0000_0003, $urandom, $urandom, 2'd2, 1, 2, 1'b0);
        // T4 second start one cycle after an accepted start
        run_op(2'd1, 2'd3, $urandom, $urandom, 32'h0, $urandom, 2'd1, 0, 0, 1'b1);
        // T5 decode timeout, then a normal op clears op_error
        run_op(2'd1, 2'd3, $urandom, $urandom, 32'h0, 32'h0, 2'd0, 0, NEVER, 1'b0);
        run_op(2'd0, 2'd0, $urandom, $urandom, $urandom, 32'h0, 2'd0, 2, 0, 1'b0);
        run_op(2'd2, 2'd1, $urandom, $urandom, $urandom, 32'h0, 2'd0, 1, NEVER, 1'b0);

        for (int i = 0; i < 30; i++) begin
            run_op(2'($urandom), 2'($urandom), $urandom, $urandom, $urandom, $urandom,
                   2'($urandom_range(2)), $urandom_range(4), $urandom_range(4),
                   1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
